uart_telemetry_scheduler: RTL and testbench

Shares the single uart_transmit instance between two telemetry requesters: YIN pitch results (taumin) and decimated processed audio samples. Each event is packed into a 4-byte framed packet. Packets are scheduled with fixed priority (taumin first), and bytes are paced against the transmitter's trigger/busy handshake. The block sits between the yin/sample pipeline and uart_transmit in top_level and replaces the direct taumin[10:3] hookup.

---
 rtl/telemetry_pkg.sv | 16 +
 rtl/telemetry_slot.sv | 43 ++++
 rtl/uart_telemetry_scheduler.sv | 150 +++++++++++++++
 tb/tb_uart_telemetry_scheduler.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/telemetry_pkg.sv
// Shared definitions for the UART telemetry scheduler: packet constants,
// FSM state encoding and byte-index sizing.
package telemetry_pkg;
    localparam int         PKT_BYTES     = 4;
    localparam int         IDX_W         = $clog2(PKT_BYTES);
    localparam logic [7:0] TYPE_TAU      = 8'h01;
    localparam logic [7:0] TYPE_SAMPLE   = 8'h02;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GUARD,
        WAIT
    } state_t;
endpackage

// File: rtl/telemetry_slot.sv
// One telemetry source: latest-wins holding register, pending flag and a
// saturating counter of values overwritten before they could be sent.
module telemetry_slot #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              capture_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              take_in,
    output logic              pending_out,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  drop_count_out
);
    logic              r_pending;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_drops;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_pending <= 1'b0;
            r_drops   <= '0;
        end else begin
            if (capture_in) begin
                r_pending <= 1'b1;
            end else if (take_in) begin
                r_pending <= 1'b0;
            end
            // A value taken this cycle is on its way out, so replacing it is not a loss
            if (capture_in && r_pending && !take_in && (r_drops != '1)) begin
                r_drops <= r_drops + CNT_W'(1);
            end
        end
        if (capture_in) begin
            r_data <= data_in;
        end
    end

    assign pending_out    = r_pending;
    assign data_out       = r_data;
    assign drop_count_out = r_drops;
endmodule

// File: rtl/uart_telemetry_scheduler.sv
// Arbitrates taumin results and decimated audio samples onto one UART
// transmitter as 4-byte framed packets, paced by the trigger/busy handshake.
module uart_telemetry_scheduler
    import telemetry_pkg::*;
#(
    parameter int         TAU_WIDTH      = 11,
    parameter int         SAMPLE_WIDTH   = 16,
    parameter int         SAMPLE_DECIM   = 256,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         DROP_CNT_WIDTH = 16
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [TAU_WIDTH-1:0]      tau_in,
    input  logic                      tau_valid_in,
    input  logic [SAMPLE_WIDTH-1:0]   sample_in,
    input  logic                      sample_valid_in,
    input  logic                      uart_busy_in,
    output logic [7:0]                data_byte_out,
    output logic                      trigger_out,
    output logic                      packet_active_out,
    output logic [DROP_CNT_WIDTH-1:0] tau_drop_count_out,
    output logic [DROP_CNT_WIDTH-1:0] sample_drop_count_out
);
    localparam int               DEC_W    = (SAMPLE_DECIM > 1) ? $clog2(SAMPLE_DECIM) : 1;
    localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(SAMPLE_DECIM - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_BYTES - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [DEC_W-1:0] r_dec_cnt;
    logic [7:0]       r_data_byte;
    logic [7:0]       r_pkt_type;
    logic [15:0]      r_pkt_payload;
    logic             r_trigger;

    logic             w_tau_pending;
    logic             w_smp_pending;
    logic             w_smp_capture;
    logic             w_tau_take;
    logic             w_smp_take;
    logic [15:0]      w_tau_held;
    logic [15:0]      w_smp_held;

    function automatic logic [7:0] pkt_byte(input logic [IDX_W-1:0] idx,
                                            input logic [7:0]       typ,
                                            input logic [15:0]      pl);
        logic [7:0] b;
        case (idx)
            IDX_W'(0): b = SYNC_BYTE;
            IDX_W'(1): b = typ;
            IDX_W'(2): b = pl[15:8];
            default:   b = pl[7:0];
        endcase
        return b;
    endfunction

    assign w_smp_capture = sample_valid_in && (r_dec_cnt == DEC_LAST);
    assign w_tau_take    = (r_state == IDLE) && w_tau_pending;
    assign w_smp_take    = (r_state == IDLE) && !w_tau_pending && w_smp_pending;

    telemetry_slot #(
        .DATA_W (16),
        .CNT_W  (DROP_CNT_WIDTH)
    ) u_tau_slot (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .capture_in     (tau_valid_in),
        .data_in        (16'(tau_in)),
        .take_in        (w_tau_take),
        .pending_out    (w_tau_pending),
        .data_out       (w_tau_held),
        .drop_count_out (tau_drop_count_out)
    );

    telemetry_slot #(
        .DATA_W (16),
        .CNT_W  (DROP_CNT_WIDTH)
    ) u_smp_slot (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .capture_in     (w_smp_capture),
        .data_in        (16'(sample_in)),
        .take_in        (w_smp_take),
        .pending_out    (w_smp_pending),
        .data_out       (w_smp_held),
        .drop_count_out (sample_drop_count_out)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_dec_cnt     <= '0;
            r_data_byte   <= '0;
            r_pkt_type    <= '0;
            r_pkt_payload <= '0;
            r_trigger     <= 1'b0;
        end else begin
            r_trigger <= 1'b0;
            if (sample_valid_in) begin
                r_dec_cnt <= (r_dec_cnt == DEC_LAST) ? '0 : r_dec_cnt + DEC_W'(1);
            end
            case (r_state)
                IDLE: begin
                    // Tau is re-examined here before every packet, giving it priority at boundaries
                    if (w_tau_pending) begin
                        r_pkt_type    <= TYPE_TAU;
                        r_pkt_payload <= w_tau_held;
                        r_idx         <= '0;
                        r_data_byte   <= SYNC_BYTE;
                        r_state       <= SEND;
                    end else if (w_smp_pending) begin
                        r_pkt_type    <= TYPE_SAMPLE;
                        r_pkt_payload <= w_smp_held;
                        r_idx         <= '0;
                        r_data_byte   <= SYNC_BYTE;
                        r_state       <= SEND;
                    end
                end
                SEND: begin
                    if (!uart_busy_in) begin
                        r_trigger <= 1'b1;
                        r_state   <= GUARD;
                    end
                end
                GUARD: begin
                    // Transmitter raises busy one cycle after the trigger, so busy is stale here
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (!uart_busy_in) begin
                        if (r_idx == IDX_LAST) begin
                            r_state <= IDLE;
                        end else begin
                            r_idx       <= r_idx + IDX_W'(1);
                            r_data_byte <= pkt_byte(r_idx + IDX_W'(1), r_pkt_type, r_pkt_payload);
                            r_state     <= SEND;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_byte_out     = r_data_byte;
    assign trigger_out       = r_trigger;
    assign packet_active_out = (r_state != IDLE);
endmodule

// File: tb/tb_uart_telemetry_scheduler.sv
// Bench for uart_telemetry_scheduler: a behavioural UART transmitter with
// one-cycle busy latency, and packet/drop expectations built from packet rules.
module tb_uart_telemetry_scheduler;
    localparam int TW  = 11;
    localparam int SW  = 16;
    localparam int DEC = 4;
    localparam int CW  = 16;
    localparam logic [7:0] T_TAU = 8'h01;
    localparam logic [7:0] T_SMP = 8'h02;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic [TW-1:0] tau_in = '0;
    logic          tau_valid_in = 1'b0;
    logic [SW-1:0] sample_in = '0;
    logic          sample_valid_in = 1'b0;
    logic          uart_busy_in = 1'b0;
    logic [7:0]    data_byte_out;
    logic          trigger_out;
    logic          packet_active_out;
    logic [CW-1:0] tau_drop_count_out;
    logic [CW-1:0] sample_drop_count_out;

    uart_telemetry_scheduler #(
        .TAU_WIDTH      (TW),
        .SAMPLE_WIDTH   (SW),
        .SAMPLE_DECIM   (DEC),
        .SYNC_BYTE      (8'hA5),
        .DROP_CNT_WIDTH (CW)
    ) dut (
        .clk_in                (clk_in),
        .rst_in                (rst_in),
        .tau_in                (tau_in),
        .tau_valid_in          (tau_valid_in),
        .sample_in             (sample_in),
        .sample_valid_in       (sample_valid_in),
        .uart_busy_in          (uart_busy_in),
        .data_byte_out         (data_byte_out),
        .trigger_out           (trigger_out),
        .packet_active_out     (packet_active_out),
        .tau_drop_count_out    (tau_drop_count_out),
        .sample_drop_count_out (sample_drop_count_out)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int busy_len = 10;
    int busy_cnt = 0;
    bit start_pend = 0;
    bit force_busy = 0;
    bit prev_trig = 0;
    bit prev_active = 0;
    bit rst_at_edge = 0;
    int trig_total = 0;
    int dbl_trig = 0;
    int trig_busy = 0;
    int early_idle = 0;
    int smp_count = 0;
    int exp_tau_drops = 0;

    always @(posedge clk_in) rst_at_edge = rst_in;

    // Transmitter model: latches the byte on trigger, raises busy one cycle later
    always @(negedge clk_in) begin
        if (trigger_out === 1'b1) begin
            trig_total++;
            rx_q.push_back(data_byte_out);
            if (prev_trig) dbl_trig++;
            if (uart_busy_in) trig_busy++;
        end
        if (start_pend) begin
            busy_cnt   = busy_len;
            start_pend = 0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        if (trigger_out === 1'b1) start_pend = 1;
        uart_busy_in = force_busy || (busy_cnt > 0);
        if (prev_active && packet_active_out === 1'b0 && uart_busy_in && !rst_at_edge) early_idle++;
        prev_trig   = (trigger_out === 1'b1);
        prev_active = (packet_active_out === 1'b1);
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        int n;
        rst_in = 1'b1;
        tau_valid_in = 1'b0;
        sample_valid_in = 1'b0;
        force_busy = 0;
        tick();
        tick();
        rst_in = 1'b0;
        n = 0;
        while (uart_busy_in && n < 300) begin
            tick();
            n++;
        end
        rx_q.delete();
        exp_q.delete();
        smp_count = 0;
        exp_tau_drops = 0;
    endtask

    task automatic send_tau(input logic [TW-1:0] v);
        tau_in = v;
        tau_valid_in = 1'b1;
        tick();
        tau_valid_in = 1'b0;
    endtask

    task automatic send_sample(input logic [SW-1:0] v, output bit cap);
        cap = (smp_count % DEC) == (DEC - 1);
        smp_count++;
        sample_in = v;
        sample_valid_in = 1'b1;
        tick();
        sample_valid_in = 1'b0;
    endtask

    task automatic exp_pkt(input logic [7:0] typ, input logic [15:0] pl);
        exp_q.push_back(8'hA5);
        exp_q.push_back(typ);
        exp_q.push_back(pl[15:8]);
        exp_q.push_back(pl[7:0]);
    endtask

    task automatic wait_idle(input string tag);
        int run;
        int n;
        run = 0;
        n = 0;
        while (run < 3 && n < 3000) begin
            tick();
            n++;
            if (!packet_active_out && !uart_busy_in) run++;
            else run = 0;
        end
        checks++;
        if (run < 3) begin
            errors++;
            $display("FAIL %s_idle_timeout: active=%0b required 0 within 3000 cycles", tag, packet_active_out);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (trigger_out !== 1'b0) begin errors++; $display("FAIL reset_trigger: got %0b required 0", trigger_out); end
        checks++;
        if (data_byte_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h required 00", data_byte_out); end
        checks++;
        if (packet_active_out !== 1'b0) begin errors++; $display("FAIL reset_active: got %0b required 0", packet_active_out); end
        checks++;
        if (tau_drop_count_out !== '0) begin errors++; $display("FAIL reset_tau_drops: got %0d required 0", tau_drop_count_out); end
        checks++;
        if (sample_drop_count_out !== '0) begin errors++; $display("FAIL reset_smp_drops: got %0d required 0", sample_drop_count_out); end
    endtask

    task automatic test_tau_only();
        int t0;
        do_reset();
        busy_len = 10;
        t0 = trig_total;
        send_tau(11'h5A3);
        tick();
        checks++;
        if (trigger_out !== 1'b0 || packet_active_out !== 1'b1) begin
            errors++; $display("FAIL tau_lat1: trig=%0b active=%0b required trig=0 active=1", trigger_out, packet_active_out);
        end
        tick();
        checks++;
        if (trigger_out !== 1'b1 || data_byte_out !== 8'hA5) begin
            errors++; $display("FAIL tau_lat2: trig=%0b data=%02h required trig=1 data=A5", trigger_out, data_byte_out);
        end
        exp_pkt(T_TAU, 16'h05A3);
        wait_idle("tau_only");
        checks++;
        if (trig_total - t0 != 4) begin errors++; $display("FAIL tau_trigs: got %0d required 4", trig_total - t0); end
        checks++;
        if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL tau_len: got %0d bytes required %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL tau_byte%0d: got %02h required %02h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_simultaneous();
        bit cap;
        do_reset();
        busy_len = 10;
        for (int i = 0; i < DEC - 1; i++) send_sample(SW'($urandom_range(0, 65535)), cap);
        tick();
        tau_in = 11'h012;
        sample_in = 16'hBEEF;
        tau_valid_in = 1'b1;
        sample_valid_in = 1'b1;
        smp_count++;
        tick();
        tau_valid_in = 1'b0;
        sample_valid_in = 1'b0;
        exp_pkt(T_TAU, 16'h0012);
        exp_pkt(T_SMP, 16'hBEEF);
        wait_idle("simul");
        checks++;
        if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL simul_len: got %0d bytes required %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL simul_byte%0d: got %02h required %02h", i, rx_q[i], exp_q[i]); end
        end
        checks++;
        if (tau_drop_count_out !== '0 || sample_drop_count_out !== '0) begin
            errors++; $display("FAIL simul_drops: got tau=%0d smp=%0d required 0/0", tau_drop_count_out, sample_drop_count_out);
        end
    endtask

    task automatic test_overwrite();
        bit cap;
        do_reset();
        busy_len = 10;
        for (int i = 0; i < DEC - 1; i++) send_sample(SW'($urandom_range(0, 65535)), cap);
        send_sample(16'h1234, cap);
        exp_pkt(T_SMP, 16'h1234);
        repeat (3) tick();
        send_tau(11'h100);
        repeat (3) tick();
        send_tau(11'h200);
        exp_pkt(T_TAU, 16'h0200);
        wait_idle("overwrite");
        checks++;
        if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL ovw_len: got %0d bytes required %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovw_byte%0d: got %02h required %02h", i, rx_q[i], exp_q[i]); end
        end
        checks++;
        if (tau_drop_count_out !== CW'(1)) begin errors++; $display("FAIL ovw_tau_drops: got %0d required 1", tau_drop_count_out); end
    endtask

    task automatic test_decimation();
        bit cap;
        do_reset();
        busy_len = 5;
        for (int i = 1; i <= 12; i++) begin
            send_sample(SW'(i), cap);
            wait_idle("decim");
        end
        exp_pkt(T_SMP, 16'd4);
        exp_pkt(T_SMP, 16'd8);
        exp_pkt(T_SMP, 16'd12);
        checks++;
        if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL decim_len: got %0d bytes required %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL decim_byte%0d: got %02h required %02h", i, rx_q[i], exp_q[i]); end
        end
        checks++;
        if (sample_drop_count_out !== '0) begin errors++; $display("FAIL decim_drops: got %0d required 0", sample_drop_count_out); end
    endtask

    task automatic test_busy_hold();
        int t0;
        int n;
        logic [TW-1:0] v;
        do_reset();
        busy_len = 7;
        force_busy = 1;
        v = TW'($urandom_range(0, 2047));
        t0 = trig_total;
        send_tau(v);
        exp_pkt(T_TAU, 16'(v));
        repeat (50) tick();
        checks++;
        if (trig_total != t0) begin errors++; $display("FAIL busy_no_trig: got %0d triggers required 0", trig_total - t0); end
        checks++;
        if (packet_active_out !== 1'b1) begin errors++; $display("FAIL busy_active: got %0b required 1", packet_active_out); end
        force_busy = 0;
        n = 0;
        while (trig_total == t0 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (trig_total == t0) begin errors++; $display("FAIL busy_release: got 0 triggers required 1 after busy low"); end
        checks++;
        if (trigger_out !== 1'b0) begin errors++; $display("FAIL busy_pulse_width: got trig=%0b required 0", trigger_out); end
        wait_idle("busy_hold");
        checks++;
        if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL busy_len: got %0d bytes required %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL busy_byte%0d: got %02h required %02h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [TW-1:0] d;
        do_reset();
        busy_len = 6;
        force_busy = 1;
        send_tau(TW'($urandom_range(0, 2047)));
        tick();
        send_tau(TW'($urandom_range(0, 2047)));
        send_tau(TW'($urandom_range(0, 2047)));
        checks++;
        if (tau_drop_count_out !== CW'(1)) begin errors++; $display("FAIL rstmid_pre_drops: got %0d required 1", tau_drop_count_out); end
        force_busy = 0;
        n = 0;
        while (trig_total < 2 && n < 500) begin
            tick();
            n++;
        end
        checks++;
        if (trig_total < 2) begin errors++; $display("FAIL rstmid_bytes: got %0d triggers required 2", trig_total); end
        repeat (2) tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        checks++;
        if (trigger_out !== 1'b0 || packet_active_out !== 1'b0 || data_byte_out !== 8'h00) begin
            errors++; $display("FAIL rstmid_outputs: trig=%0b active=%0b data=%02h required 0/0/00", trigger_out, packet_active_out, data_byte_out);
        end
        checks++;
        if (tau_drop_count_out !== '0 || sample_drop_count_out !== '0) begin
            errors++; $display("FAIL rstmid_drops: got tau=%0d smp=%0d required 0/0", tau_drop_count_out, sample_drop_count_out);
        end
        n = 0;
        while (uart_busy_in && n < 300) begin
            tick();
            n++;
        end
        rx_q.delete();
        exp_q.delete();
        smp_count = 0;
        d = TW'($urandom_range(0, 2047));
        send_tau(d);
        exp_pkt(T_TAU, 16'(d));
        wait_idle("rst_mid");
        checks++;
        if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_len: got %0d bytes required %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_byte%0d: got %02h required %02h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        int op;
        int k;
        bit cap;
        logic [TW-1:0] tv;
        logic [SW-1:0] sv;
        do_reset();
        for (int it = 0; it < 30; it++) begin
            op = $urandom_range(0, 2);
            busy_len = $urandom_range(1, 12);
            case (op)
                0: begin
                    tv = TW'($urandom_range(0, 2047));
                    send_tau(tv);
                    exp_pkt(T_TAU, 16'(tv));
                end
                1: begin
                    k = $urandom_range(1, 6);
                    for (int j = 0; j < k; j++) begin
                        sv = SW'($urandom_range(0, 65535));
                        send_sample(sv, cap);
                        if (cap) exp_pkt(T_SMP, 16'(sv));
                        repeat ($urandom_range(0, 3)) tick();
                    end
                end
                default: begin
                    busy_len = $urandom_range(4, 12);
                    k = $urandom_range(2, 4);
                    tv = '0;
                    for (int j = 0; j < k; j++) begin
                        tv = TW'($urandom_range(0, 2047));
                        send_tau(tv);
                        if (j == 0) exp_pkt(T_TAU, 16'(tv));
                        repeat ($urandom_range(1, 3)) tick();
                    end
                    exp_pkt(T_TAU, 16'(tv));
                    exp_tau_drops += k - 2;
                end
            endcase
            wait_idle("random");
        end
        checks++;
        if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_len: got %0d bytes required %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte%0d: got %02h required %02h", i, rx_q[i], exp_q[i]); end
        end
        checks++;
        if (tau_drop_count_out !== CW'(exp_tau_drops)) begin
            errors++; $display("FAIL rand_tau_drops: got %0d required %0d", tau_drop_count_out, exp_tau_drops);
        end
        checks++;
        if (sample_drop_count_out !== '0) begin errors++; $display("FAIL rand_smp_drops: got %0d required 0", sample_drop_count_out); end
    endtask

    task automatic test_protocol();
        checks++;
        if (dbl_trig != 0) begin errors++; $display("FAIL proto_double_trigger: got %0d required 0", dbl_trig); end
        checks++;
        if (trig_busy != 0) begin errors++; $display("FAIL proto_trigger_while_busy: got %0d required 0", trig_busy); end
        checks++;
        if (early_idle != 0) begin errors++; $display("FAIL proto_early_idle: got %0d required 0", early_idle); end
    endtask

    initial begin
        test_reset();
        test_tau_only();
        test_simultaneous();
        test_overwrite();
        test_decimation();
        test_busy_hold();
        test_reset_mid();
        test_random();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
